// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: synchronised buttons drive an IDLE/MOVING FSM
// with tick-paced acceleration and per-axis clamp or wrap at the playfield edges.
module sprite_motion_ctrl #(
    parameter int c_POS_W         = 10,
    parameter int c_GAME_WIDTH    = 640,
    parameter int c_GAME_HEIGHT   = 480,
    parameter int c_PLAYER_WIDTH  = 32,
    parameter int c_PLAYER_HEIGHT = 32,
    parameter int c_TICK_DIV      = 833333,
    parameter int c_SPEED_MIN     = 2,
    parameter int c_SPEED_MAX     = 10,
    parameter int c_ACCEL_TICKS   = 4,
    parameter int c_WRAP          = 0
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Up,
    input  logic               i_Dn,
    input  logic               i_Lt,
    input  logic               i_Rt,
    input  logic               i_Load,
    input  logic [c_POS_W-1:0] i_Load_X,
    input  logic [c_POS_W-1:0] i_Load_Y,
    output logic [c_POS_W-1:0] o_X,
    output logic [c_POS_W-1:0] o_Y,
    output logic               o_Tick,
    output logic               o_Moving,
    output logic [3:0]         o_Speed,
    output logic               o_Hit_Edge
);

    localparam int MAX_X = c_GAME_WIDTH - c_PLAYER_WIDTH;
    localparam int MAX_Y = c_GAME_HEIGHT - c_PLAYER_HEIGHT;
    localparam int CW    = c_POS_W + 2;
    localparam int TW    = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int HW    = (c_ACCEL_TICKS > 1) ? $clog2(c_ACCEL_TICKS + 1) : 1;

    localparam logic [TW-1:0]          TICK_LAST = TW'(c_TICK_DIV - 1);
    localparam logic [HW-1:0]          HELD_LAST = HW'(c_ACCEL_TICKS);
    localparam logic [3:0]             SPD_MIN   = 4'(c_SPEED_MIN);
    localparam logic [3:0]             SPD_MAX   = 4'(c_SPEED_MAX);
    localparam logic [c_POS_W-1:0]     MAX_XP    = c_POS_W'(MAX_X);
    localparam logic [c_POS_W-1:0]     MAX_YP    = c_POS_W'(MAX_Y);
    localparam logic [c_POS_W-1:0]     HOME_X    = c_POS_W'(MAX_X / 2);
    localparam logic [c_POS_W-1:0]     HOME_Y    = c_POS_W'(MAX_Y / 2);
    localparam logic signed [CW-1:0]   MAX_XS    = CW'(MAX_X);
    localparam logic signed [CW-1:0]   MAX_YS    = CW'(MAX_Y);

    typedef enum logic {IDLE, MOVING} state_t;

    state_t             state, state_nx;
    logic [3:0]         btn_meta, btn_sync;
    logic [TW-1:0]      tick_cnt;
    logic [HW-1:0]      held, held_nx, held_inc;
    logic [3:0]         speed, speed_nx;
    logic [c_POS_W-1:0] pos_x, pos_y, pos_x_nx, pos_y_nx;
    logic               hit, hit_nx;
    logic               tick;
    logic               dec_x, inc_x, dec_y, inc_y, any_dir;
    logic [c_POS_W:0]   step_x, step_y;

    // Returns {edge_event, new_position} for one axis.
    function automatic logic [c_POS_W:0] move_axis(
        input logic [c_POS_W-1:0]   pos,
        input logic                 dec,
        input logic                 inc,
        input logic [3:0]           spd,
        input logic signed [CW-1:0] lim
    );
        logic signed [CW-1:0] cand;
        logic signed [CW-1:0] delta;
        logic                 edge_hit;
        delta    = {{(CW-4){1'b0}}, spd};
        cand     = {2'b00, pos};
        edge_hit = 1'b0;
        if (dec)
            cand = cand - delta;
        else if (inc)
            cand = cand + delta;
        if (cand[CW-1]) begin
            edge_hit = 1'b1;
            cand     = (c_WRAP != 0) ? cand + lim + CW'(1) : '0;
        end else if (cand > lim) begin
            edge_hit = 1'b1;
            cand     = (c_WRAP != 0) ? cand - lim - CW'(1) : lim;
        end
        return {edge_hit, cand[c_POS_W-1:0]};
    endfunction

    assign tick     = (tick_cnt == TICK_LAST);
    assign dec_y    = btn_sync[3] & ~btn_sync[2];
    assign inc_y    = btn_sync[2] & ~btn_sync[3];
    assign dec_x    = btn_sync[1] & ~btn_sync[0];
    assign inc_x    = btn_sync[0] & ~btn_sync[1];
    assign any_dir  = dec_x | inc_x | dec_y | inc_y;
    assign held_inc = held + HW'(1);
    assign step_x   = move_axis(pos_x, dec_x, inc_x, speed, MAX_XS);
    assign step_y   = move_axis(pos_y, dec_y, inc_y, speed, MAX_YS);

    always_comb begin
        state_nx = state;
        speed_nx = speed;
        held_nx  = held;
        pos_x_nx = pos_x;
        pos_y_nx = pos_y;
        hit_nx   = 1'b0;
        if (i_Load) begin
            pos_x_nx = (i_Load_X > MAX_XP) ? MAX_XP : i_Load_X;
            pos_y_nx = (i_Load_Y > MAX_YP) ? MAX_YP : i_Load_Y;
            state_nx = IDLE;
            speed_nx = SPD_MIN;
            held_nx  = '0;
        end else if (tick) begin
            // Step uses the pre-tick speed; the entry tick counts as a held tick.
            pos_x_nx = step_x[c_POS_W-1:0];
            pos_y_nx = step_y[c_POS_W-1:0];
            hit_nx   = step_x[c_POS_W] | step_y[c_POS_W];
            if (any_dir) begin
                state_nx = MOVING;
                if (held_inc == HELD_LAST) begin
                    held_nx = '0;
                    if (speed < SPD_MAX)
                        speed_nx = speed + 4'd1;
                end else begin
                    held_nx = held_inc;
                end
            end else begin
                state_nx = IDLE;
                speed_nx = SPD_MIN;
                held_nx  = '0;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            tick_cnt <= '0;
            state    <= IDLE;
            speed    <= SPD_MIN;
            held     <= '0;
            pos_x    <= HOME_X;
            pos_y    <= HOME_Y;
            hit      <= 1'b0;
        end else begin
            btn_meta <= {i_Up, i_Dn, i_Lt, i_Rt};
            btn_sync <= btn_meta;
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            state    <= state_nx;
            speed    <= speed_nx;
            held     <= held_nx;
            pos_x    <= pos_x_nx;
            pos_y    <= pos_y_nx;
            hit      <= hit_nx;
        end
    end

    assign o_X        = pos_x;
    assign o_Y        = pos_y;
    assign o_Tick     = tick;
    assign o_Moving   = (state == MOVING);
    assign o_Speed    = speed;
    assign o_Hit_Edge = hit;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: a clamp instance driven from a vector
// table plus hand sequences for reset timing, wrap, load override and reset.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       rst, up, dn, lt, rt, load;
    logic [9:0] lx, ly;
    logic [9:0] x, y, wx, wy;
    logic       tick, moving, hit, wtick, wmoving, whit;
    logic [3:0] speed, wspeed;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl #(
        .c_POS_W(10), .c_GAME_WIDTH(640), .c_GAME_HEIGHT(480),
        .c_PLAYER_WIDTH(32), .c_PLAYER_HEIGHT(32), .c_TICK_DIV(4),
        .c_SPEED_MIN(2), .c_SPEED_MAX(4), .c_ACCEL_TICKS(3), .c_WRAP(0)
    ) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
        .i_Load(load), .i_Load_X(lx), .i_Load_Y(ly),
        .o_X(x), .o_Y(y), .o_Tick(tick), .o_Moving(moving),
        .o_Speed(speed), .o_Hit_Edge(hit)
    );

    sprite_motion_ctrl #(
        .c_POS_W(10), .c_GAME_WIDTH(640), .c_GAME_HEIGHT(480),
        .c_PLAYER_WIDTH(32), .c_PLAYER_HEIGHT(32), .c_TICK_DIV(4),
        .c_SPEED_MIN(2), .c_SPEED_MAX(4), .c_ACCEL_TICKS(3), .c_WRAP(1)
    ) dut_wrap (
        .i_Clk(clk), .i_Rst(rst), .i_Up(up), .i_Dn(dn), .i_Lt(lt), .i_Rt(rt),
        .i_Load(load), .i_Load_X(lx), .i_Load_Y(ly),
        .o_X(wx), .o_Y(wy), .o_Tick(wtick), .o_Moving(wmoving),
        .o_Speed(wspeed), .o_Hit_Edge(whit)
    );

    typedef struct {
        logic [3:0] btn;   // {up, dn, lt, rt}
        logic       ld;
        int         lx, ly;
        int         ex, ey, emv, esp, ehit;
    } vec_t;

    localparam int NV = 24;
    vec_t tbl[NV];

    function automatic vec_t mk(input logic [3:0] btn, input logic ld, input int lxv,
                                input int lyv, input int ex, input int ey,
                                input int emv, input int esp, input int ehit);
        vec_t v;
        v.btn = btn; v.ld = ld; v.lx = lxv; v.ly = lyv;
        v.ex = ex; v.ey = ey; v.emv = emv; v.esp = esp; v.ehit = ehit;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits (bounded) for the next tick, then returns just after the edge that applies it.
    task automatic wait_tick(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_tick_seen"}, int'(ok), 1);
        @(posedge clk);
        #1;
    endtask

    // Counts negedges after reset release until the first tick (bounded).
    task automatic first_tick_after_release(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (tick) begin
                n = i;
                break;
            end
        end
        chk(name, n, 4);
    endtask

    task automatic set_btn(input logic [3:0] b);
        {up, dn, lt, rt} = b;
    endtask

    task automatic pulse_load(input int xv, input int yv);
        load = 1'b1; lx = 10'(xv); ly = 10'(yv);
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    initial begin
        // {up,dn,lt,rt}, load, lx, ly, x, y, moving, speed, hit
        tbl[0]  = mk(4'b0001, 0, 0, 0, 306, 224, 1, 2, 0);
        tbl[1]  = mk(4'b0001, 0, 0, 0, 308, 224, 1, 2, 0);
        tbl[2]  = mk(4'b0001, 0, 0, 0, 310, 224, 1, 3, 0);
        tbl[3]  = mk(4'b0001, 0, 0, 0, 313, 224, 1, 3, 0);
        tbl[4]  = mk(4'b0001, 0, 0, 0, 316, 224, 1, 3, 0);
        tbl[5]  = mk(4'b0001, 0, 0, 0, 319, 224, 1, 4, 0);
        tbl[6]  = mk(4'b0001, 0, 0, 0, 323, 224, 1, 4, 0);
        tbl[7]  = mk(4'b0001, 0, 0, 0, 327, 224, 1, 4, 0);
        tbl[8]  = mk(4'b0001, 0, 0, 0, 331, 224, 1, 4, 0);
        tbl[9]  = mk(4'b0001, 0, 0, 0, 335, 224, 1, 4, 0);
        tbl[10] = mk(4'b0000, 0, 0, 0, 335, 224, 0, 2, 0);
        tbl[11] = mk(4'b1100, 0, 0, 0, 335, 224, 0, 2, 0);
        tbl[12] = mk(4'b1000, 0, 0, 0, 335, 222, 1, 2, 0);
        tbl[13] = mk(4'b1010, 0, 0, 0, 333, 220, 1, 2, 0);
        tbl[14] = mk(4'b1010, 0, 0, 0, 331, 218, 1, 3, 0);
        tbl[15] = mk(4'b0000, 0, 0, 0, 331, 218, 0, 2, 0);
        tbl[16] = mk(4'b0001, 1, 605, 224, 607, 224, 1, 2, 0);
        tbl[17] = mk(4'b0001, 0, 0, 0, 608, 224, 1, 2, 1);
        tbl[18] = mk(4'b0001, 0, 0, 0, 608, 224, 1, 3, 1);
        tbl[19] = mk(4'b0001, 0, 0, 0, 608, 224, 1, 3, 1);
        tbl[20] = mk(4'b1010, 1, 0, 0, 0, 0, 1, 2, 1);
        tbl[21] = mk(4'b0100, 1, 3, 500, 3, 448, 1, 2, 1);
        tbl[22] = mk(4'b0000, 0, 0, 0, 3, 448, 0, 2, 0);
        tbl[23] = mk(4'b0000, 1, 10, 20, 10, 20, 0, 2, 0);

        rst = 1'b1; load = 1'b0; lx = '0; ly = '0;
        set_btn(4'b0000);

        // Reset values and tick timing out of reset.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", int'(x), 304);
        chk("rst_y", int'(y), 224);
        chk("rst_moving", int'(moving), 0);
        chk("rst_speed", int'(speed), 2);
        chk("rst_hit", int'(hit), 0);
        chk("rst_tick", int'(tick), 0);
        rst = 1'b0;
        first_tick_after_release("first_tick_delay");
        begin
            int nt;
            nt = 0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (tick) nt++;
            end
            chk("ticks_in_later_16_cycles", nt, 4);
        end
        chk("idle_x", int'(x), 304);
        chk("idle_y", int'(y), 224);
        chk("idle_moving", int'(moving), 0);

        // Align to just after a tick edge so button changes sync before the next tick.
        wait_tick("align");

        for (int i = 0; i < NV; i++) begin
            set_btn(tbl[i].btn);
            if (tbl[i].ld) pulse_load(tbl[i].lx, tbl[i].ly);
            wait_tick($sformatf("v%0d", i));
            chk($sformatf("v%0d_x", i), int'(x), tbl[i].ex);
            chk($sformatf("v%0d_y", i), int'(y), tbl[i].ey);
            chk($sformatf("v%0d_moving", i), int'(moving), tbl[i].emv);
            chk($sformatf("v%0d_speed", i), int'(speed), tbl[i].esp);
            chk($sformatf("v%0d_hit", i), int'(hit), tbl[i].ehit);
        end

        // Wrap instance: both axes wrap low, then X wraps high.
        set_btn(4'b1010);
        pulse_load(1, 0);
        wait_tick("wrap_lo");
        chk("wrap_lo_x", int'(wx), 608);
        chk("wrap_lo_y", int'(wy), 447);
        chk("wrap_lo_hit", int'(whit), 1);
        chk("clamp_lo_x", int'(x), 0);
        chk("clamp_lo_y", int'(y), 0);
        set_btn(4'b0001);
        pulse_load(607, 100);
        wait_tick("wrap_hi");
        chk("wrap_hi_x", int'(wx), 0);
        chk("wrap_hi_y", int'(wy), 100);
        chk("wrap_hi_hit", int'(whit), 1);
        set_btn(4'b0000);
        wait_tick("wrap_stop");
        chk("wrap_stop_x", int'(wx), 0);
        chk("wrap_stop_hit", int'(whit), 0);
        chk("wrap_stop_moving", int'(wmoving), 0);

        // Load coincident with a tick while pushing into the right edge.
        set_btn(4'b0001);
        pulse_load(607, 224);
        wait_tick("pre_load_a");
        wait_tick("pre_load_b");
        chk("pre_load_hit", int'(hit), 1);
        begin
            bit ok;
            ok = 1'b0;
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                if (tick) begin
                    ok = 1'b1;
                    break;
                end
            end
            chk("coinc_tick_seen", int'(ok), 1);
            load = 1'b1; lx = 10'd700; ly = 10'd10;
            @(posedge clk);
            #1;
            load = 1'b0;
        end
        chk("coinc_x", int'(x), 608);
        chk("coinc_y", int'(y), 10);
        chk("coinc_moving", int'(moving), 0);
        chk("coinc_hit", int'(hit), 0);
        chk("coinc_speed", int'(speed), 2);

        // Build speed to the maximum, then reset mid-motion.
        for (int i = 0; i < 7; i++) wait_tick($sformatf("accel%0d", i));
        chk("accel_speed", int'(speed), 4);
        chk("accel_moving", int'(moving), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_x", int'(x), 304);
        chk("mid_rst_y", int'(y), 224);
        chk("mid_rst_speed", int'(speed), 2);
        chk("mid_rst_moving", int'(moving), 0);
        chk("mid_rst_hit", int'(hit), 0);
        chk("mid_rst_tick", int'(tick), 0);
        set_btn(4'b0000);
        rst = 1'b0;
        first_tick_after_release("mid_rst_first_tick");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): c_POS_W, 10, position width; c_GAME_WIDTH, 640, playfield width; c_GAME_HEIGHT, 480, playfield height; c_PLAYER_WIDTH, 32, sprite width; c_PLAYER_HEIGHT, 32, sprite height; c_TICK_DIV, 833333, clocks per movement tick; c_SPEED_MIN, 2, start speed in px/tick; c_SPEED_MAX, 10, top speed in px/tick; c_ACCEL_TICKS, 4, held ticks per +1 speed step; c_WRAP, 0, edge mode (0 = clamp, 1 = wrap).
REQ-002 Ports SHALL be (name, direction, width, meaning): i_Clk, in, 1, single clock; i_Rst, in, 1, reset, synchronous, active-high; i_Up/i_Dn/i_Lt/i_Rt, in, 1 each, asynchronous buttons; i_Load, in, 1, position load strobe; i_Load_X, in, c_POS_W, load X; i_Load_Y, in, c_POS_W, load Y; o_X, out, c_POS_W, sprite X; o_Y, out, c_POS_W, sprite Y; o_Tick, out, 1, one-cycle movement-tick pulse; o_Moving, out, 1, state is MOVING; o_Speed, out, 4, current speed; o_Hit_Edge, out, 1, one-cycle clamp/wrap event pulse.
REQ-003 Bounds SHALL be MAX_X = c_GAME_WIDTH - c_PLAYER_WIDTH and MAX_Y = c_GAME_HEIGHT - c_PLAYER_HEIGHT; c_SPEED_MIN <= c_SPEED_MAX <= 15 and c_SPEED_MAX <= MAX_X, MAX_Y are legal-configuration requirements.

Function
REQ-004 Each button SHALL pass through a 2-flop synchronizer clocked by i_Clk; movement logic SHALL use only the synchronized values.
REQ-005 The tick counter SHALL count 0..c_TICK_DIV-1 and wrap; o_Tick SHALL be 1 exactly in the cycle the count equals c_TICK_DIV-1.
REQ-006 No derived or gated clock SHALL be used; all state SHALL update on posedge i_Clk, qualified by o_Tick.
REQ-007 On a tick, per-axis direction SHALL be: Up&!Dn -> -1; Dn&!Up -> +1; otherwise 0; X likewise with Lt (-1) and Rt (+1).
REQ-008 The FSM SHALL have states IDLE and MOVING. IDLE->MOVING on a tick with any nonzero axis direction. MOVING->IDLE on a tick with both directions 0. Opposing-only presses count as zero.
REQ-009 On entry to MOVING the speed SHALL be c_SPEED_MIN. A held-tick counter SHALL increment each tick spent in MOVING; on reaching c_ACCEL_TICKS the speed SHALL increment by 1, saturating at c_SPEED_MAX, and the counter SHALL clear. In IDLE, speed = c_SPEED_MIN and counter = 0.
REQ-010 The position step on a tick SHALL use the speed value held before that tick's update. The entry tick (IDLE->MOVING) SHALL also move, by c_SPEED_MIN.
REQ-011 The candidate position SHALL be computed signed at c_POS_W+2 bits: cand = pos + dir*speed.
REQ-012 With c_WRAP=0: cand < 0 -> 0; cand > MAX -> MAX; either case SHALL pulse o_Hit_Edge. A sprite already at the edge and pushed further SHALL stay put and still pulse o_Hit_Edge.
REQ-013 With c_WRAP=1: cand < 0 -> cand + MAX + 1; cand > MAX -> cand - MAX - 1; either case SHALL pulse o_Hit_Edge.
REQ-014 o_Hit_Edge SHALL be registered, asserted in the cycle after the tick, and be the OR of the X and Y events.
REQ-015 i_Load SHALL apply in any cycle: o_X = min(i_Load_X, MAX_X), o_Y = min(i_Load_Y, MAX_Y); FSM -> IDLE; speed reset. i_Load SHALL override a coincident tick's movement, and o_Hit_Edge SHALL stay 0 for that tick.
REQ-016 Diagonal movement SHALL apply the same speed to both axes independently; each axis SHALL clamp or wrap independently.

Reset
REQ-017 i_Rst SHALL take priority over i_Load and ticks.
REQ-018 On reset: o_X = MAX_X/2 (floor); o_Y = MAX_Y/2 (floor); tick counter, held counter and synchronizers = 0; state IDLE; o_Speed = c_SPEED_MIN; o_Tick, o_Moving, o_Hit_Edge = 0.
REQ-019 Reset asserted mid-MOVING SHALL discard accumulated speed; the first tick after reset release SHALL occur c_TICK_DIV cycles after release.

Verification (c_TICK_DIV=4, c_ACCEL_TICKS=3, c_SPEED_MIN=2, c_SPEED_MAX=4, 640x480, 32x32 sprite)
REQ-020 Reset, then idle 20 cycles -> o_X=304, o_Y=224, o_Tick period 4 cycles, o_Moving=0.
REQ-021 Hold i_Rt for 10 ticks -> X steps +2,+2,+2,+3,+3,+3,+4,+4,+4,+4 (X=335); release -> next tick o_Moving=0, o_Speed=2.
REQ-022 Clamp: load X=605, hold i_Rt -> X=607, then 608 with o_Hit_Edge pulse, then 608 with a pulse each tick; Up+Dn held -> Y unchanged, o_Moving stays 0.
REQ-023 Wrap (c_WRAP=1): load X=1, hold i_Lt -> X=608 (1-2+609) with o_Hit_Edge pulse.
REQ-024 i_Load with X=700, Y=10 coincident with a tick while Rt held -> X=608, Y=10, IDLE, no o_Hit_Edge; i_Rst asserted during MOVING at speed 4 -> REQ-018 values next cycle.
